// File: rtl/vram_slot_arbiter_if.sv
// Bus bundle between the video timing/BG fetcher/CPU side and the VRAM slot arbiter.
// The arbiter takes the slave view; the surrounding system, or a bench, takes the master view.
interface vram_slot_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              ce_pix;
  logic [8:0]        hcount;
  logic              hb;
  logic              vb;
  logic [ADDR_W-1:0] bg_addr;
  logic [DATA_W-1:0] bg_data;
  logic              bg_valid;
  logic [1:0]        bg_phase;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_wait;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  ce_pix, hcount, hb, vb, bg_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output bg_data, bg_valid, bg_phase,
    output cpu_dout, cpu_ack, cpu_wait,
    output ram_addr, ram_we, ram_din
  );

  modport master (
    output ce_pix, hcount, hb, vb, bg_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  bg_data, bg_valid, bg_phase,
    input  cpu_dout, cpu_ack, cpu_wait,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one synchronous VRAM port between the BG tile fetcher and the CPU.
// Even pixel slots in active display belong to BG; all other slots go to a pending CPU request.
module vram_slot_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  vram_slot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAM  = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t state, state_next;

  logic owner_bg;
  logic owner_we;
  logic served;
  logic cpu_pending;
  logic bg_slot;
  logic grant_bg;
  logic grant_cpu;
  logic capture;

  // Only hcount[2:0] matters for slot ownership and fetch phase.
  logic unused_hcount;
  assign unused_hcount = &{1'b0, bus.hcount[8:3]};

  // served blocks a held request from being granted a second time.
  assign cpu_pending  = bus.cpu_req & ~served;
  assign bg_slot      = ~bus.hcount[0] & ~bus.hb & ~bus.vb;
  assign bus.cpu_wait = cpu_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: every register uses <= so all flops sample pre-edge values, as real hardware does.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    grant_bg   = 1'b0;
    grant_cpu  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce_pix) begin
          if (bg_slot) begin
            grant_bg = 1'b1;
          end else if (cpu_pending) begin
            grant_cpu = 1'b1;
          end
          if (grant_bg || grant_cpu) begin
            state_next = RAM;
          end
        end
      end
      RAM: state_next = CAP;
      CAP: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ram_addr <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_din  <= '0;
      bus.bg_data  <= '0;
      bus.bg_phase <= 2'd0;
      bus.bg_valid <= 1'b0;
      bus.cpu_dout <= '0;
      bus.cpu_ack  <= 1'b0;
      owner_bg     <= 1'b0;
      owner_we     <= 1'b0;
      served       <= 1'b0;
    end else begin
      // Write enable lives only in the RAM cycle; the next grant is at least one cycle away.
      bus.ram_we   <= grant_cpu & bus.cpu_we;
      bus.bg_valid <= capture & owner_bg;
      bus.cpu_ack  <= capture & ~owner_bg;

      if (grant_bg) begin
        bus.ram_addr <= bus.bg_addr;
        bus.bg_phase <= bus.hcount[2:1];
        owner_bg     <= 1'b1;
        owner_we     <= 1'b0;
      end

      if (grant_cpu) begin
        bus.ram_addr <= bus.cpu_addr;
        bus.ram_din  <= bus.cpu_din;
        owner_bg     <= 1'b0;
        owner_we     <= bus.cpu_we;
      end

      if (capture) begin
        if (owner_bg) begin
          bus.bg_data <= bus.ram_dout;
        end else if (!owner_we) begin
          bus.cpu_dout <= bus.ram_dout;
        end
      end

      if (capture && !owner_bg) begin
        served <= 1'b1;
      end else if (!bus.cpu_req) begin
        served <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter: table-driven pixel vectors, a strobe scoreboard
// fed by a small slot/RAM model, and hand sequences for CPU handshake and reset corners.
module tb_vram_slot_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_slot_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_slot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read RAM with one clk latency; reads return old data on a same-cycle write.
  logic [7:0] mem    [0:8191];
  logic [7:0] shadow [0:8191];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  typedef struct {
    int         due;
    logic       rd;
    logic [7:0] data;
    logic [1:0] phase;
  } exp_t;

  typedef struct {
    logic [8:0] hc;
    logic       hb;
    logic       vb;
    logic       exp_bg;
    logic [1:0] exp_phase;
    logic [7:0] exp_data;
  } vec_t;

  exp_t bg_q[$];
  exp_t cpu_q[$];
  vec_t vec[17];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bg_cnt   = 0;
  int ack_cnt  = 0;
  int we_cnt   = 0;
  logic [8:0] we_hc = '0;
  logic [1:0] last_phase = '0;
  logic [7:0] last_bg = '0;
  logic       prev_wait = 1'b0;
  logic       m_served = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.ram_we) begin
        we_cnt++;
        we_hc = bus.hcount;
      end
      if (bg_q.size() > 0 && bg_q[0].due < cyc) begin
        check("bg_valid_missing", {31'd0, bus.bg_valid}, 32'd1);
        void'(bg_q.pop_front());
      end
      if (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
        check("cpu_ack_missing", {31'd0, bus.cpu_ack}, 32'd1);
        void'(cpu_q.pop_front());
      end
      if (bus.bg_valid) begin
        bg_cnt++;
        last_phase = bus.bg_phase;
        last_bg    = bus.bg_data;
        if (bg_q.size() == 0) begin
          check("bg_valid_unexpected", 32'd1, 32'd0);
        end else begin
          e = bg_q.pop_front();
          check("bg_latency_cyc", cyc, e.due);
          check("bg_phase", {30'd0, bus.bg_phase}, {30'd0, e.phase});
          check("bg_data", {24'd0, bus.bg_data}, {24'd0, e.data});
        end
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        check("cpu_wait_at_ack", {31'd0, bus.cpu_wait}, 32'd0);
        check("cpu_wait_before_ack", {31'd0, prev_wait}, 32'd1);
        if (cpu_q.size() == 0) begin
          check("cpu_ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_latency_cyc", cyc, e.due);
          if (e.rd) check("cpu_dout", {24'd0, bus.cpu_dout}, {24'd0, e.data});
        end
      end
      prev_wait = bus.cpu_wait;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel slot: ce_pix for one clk, then three idle clks. The model predicts the owner.
  task automatic pix(input logic [8:0] hc, input logic h, input logic v);
    exp_t e;
    bus.ce_pix  = 1'b1;
    bus.hcount  = hc;
    bus.hb      = h;
    bus.vb      = v;
    bus.bg_addr = 13'h100 + 13'(hc);
    e.due = cyc + 3;
    e.rd = 1'b0;
    e.data = 8'h00;
    e.phase = 2'd0;
    if (!hc[0] && !h && !v) begin
      e.phase = hc[2:1];
      e.data  = shadow[13'h100 + 13'(hc)];
      bg_q.push_back(e);
    end else if (bus.cpu_req && !m_served) begin
      m_served = 1'b1;
      e.rd = !bus.cpu_we;
      if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_din;
      else e.data = shadow[bus.cpu_addr];
      cpu_q.push_back(e);
    end
    tick();
    bus.ce_pix = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic run_vec(input int lo, input int hi);
    int b0;
    for (int i = lo; i <= hi; i++) begin
      b0 = bg_cnt;
      pix(vec[i].hc, vec[i].hb, vec[i].vb);
      check("vec_bg_count", bg_cnt - b0, {31'd0, vec[i].exp_bg});
      if (vec[i].exp_bg) begin
        check("vec_bg_phase", {30'd0, last_phase}, {30'd0, vec[i].exp_phase});
        check("vec_bg_data", {24'd0, last_bg}, {24'd0, vec[i].exp_data});
      end
    end
  endtask

  task automatic cpu_set(input logic we, input logic [12:0] addr, input logic [7:0] din);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
  endtask

  task automatic cpu_drop();
    bus.cpu_req = 1'b0;
    m_served = 1'b0;
    tick();
  endtask

  initial begin
    int a0;
    int w0;
    vec[0] = '{9'd16, 1'b0, 1'b0, 1'b1, 2'd0, 8'h10};
    vec[1] = '{9'd17, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vec[2] = '{9'd18, 1'b0, 1'b0, 1'b1, 2'd1, 8'h12};
    vec[3] = '{9'd19, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vec[4] = '{9'd20, 1'b0, 1'b0, 1'b1, 2'd2, 8'h14};
    vec[5] = '{9'd21, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vec[6] = '{9'd22, 1'b0, 1'b0, 1'b1, 2'd3, 8'h16};
    vec[7] = '{9'd23, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    for (int i = 0; i < 9; i++) vec[8 + i] = '{9'(272 + i), 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

    for (int i = 0; i < 8192; i++) begin
      mem[i]    = 8'(i);
      shadow[i] = 8'(i);
    end

    bus.ce_pix = 1'b0; bus.hcount = '0; bus.hb = 1'b0; bus.vb = 1'b0; bus.bg_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    reset = 1'b1;
    tick();
    tick();

    check("rst_ram_addr", {19'd0, bus.ram_addr}, 32'd0);
    check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    check("rst_bg_valid", {31'd0, bus.bg_valid}, 32'd0);
    check("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_cpu_wait", {31'd0, bus.cpu_wait}, 32'd0);
    reset = 1'b0;
    tick();

    // Active line BG fetches.
    run_vec(0, 7);

    // CPU write then read in active display.
    cpu_set(1'b1, 13'h0123, 8'h5A);
    #1;
    check("wr_wait_raised", {31'd0, bus.cpu_wait}, 32'd1);
    w0 = we_cnt;
    a0 = ack_cnt;
    pix(9'd20, 1'b0, 1'b0);
    check("wr_wait_held_bg_slot", {31'd0, bus.cpu_wait}, 32'd1);
    pix(9'd21, 1'b0, 1'b0);
    check("wr_we_pulses", we_cnt - w0, 32'd1);
    check("wr_we_hcount", {23'd0, we_hc}, 32'd21);
    check("wr_ack_count", ack_cnt - a0, 32'd1);
    cpu_drop();
    cpu_set(1'b0, 13'h0123, 8'h00);
    pix(9'd22, 1'b0, 1'b0);
    pix(9'd23, 1'b0, 1'b0);
    check("rd_cpu_dout", {24'd0, bus.cpu_dout}, 32'h5A);
    check("rd_ack_count", ack_cnt - a0, 32'd2);
    cpu_drop();

    // Held write request: serviced exactly once until dropped and re-asserted.
    cpu_set(1'b1, 13'h0200, 8'hA5);
    w0 = we_cnt;
    a0 = ack_cnt;
    for (int hc = 32; hc <= 43; hc++) pix(9'(hc), 1'b0, 1'b0);
    check("held_we_pulses", we_cnt - w0, 32'd1);
    check("held_ack_count", ack_cnt - a0, 32'd1);
    check("held_wait_low", {31'd0, bus.cpu_wait}, 32'd0);
    cpu_drop();
    cpu_set(1'b0, 13'h0200, 8'h00);
    pix(9'd44, 1'b0, 1'b0);
    pix(9'd45, 1'b0, 1'b0);
    check("reassert_ack_count", ack_cnt - a0, 32'd2);
    check("reassert_cpu_dout", {24'd0, bus.cpu_dout}, 32'hA5);
    cpu_drop();

    // Horizontal blanking: no BG fetch, CPU read granted on an even slot.
    cpu_set(1'b0, 13'h0123, 8'h00);
    a0 = ack_cnt;
    run_vec(8, 16);
    check("blank_ack_count", ack_cnt - a0, 32'd1);
    check("blank_cpu_dout", {24'd0, bus.cpu_dout}, 32'h5A);
    cpu_drop();

    // Reset asserted while a CPU write sits in the RAM state.
    cpu_set(1'b1, 13'h0300, 8'h3C);
    bus.ce_pix = 1'b1; bus.hcount = 9'd47; bus.hb = 1'b0; bus.vb = 1'b0;
    bus.bg_addr = 13'h100 + 13'd47;
    tick();
    bus.ce_pix = 1'b0;
    check("pre_rst_ram_we", {31'd0, bus.ram_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_ram_addr", {19'd0, bus.ram_addr}, 32'd0);
    check("midrst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    check("midrst_ram_din", {24'd0, bus.ram_din}, 32'd0);
    check("midrst_bg_data", {24'd0, bus.bg_data}, 32'd0);
    check("midrst_bg_phase", {30'd0, bus.bg_phase}, 32'd0);
    check("midrst_bg_valid", {31'd0, bus.bg_valid}, 32'd0);
    check("midrst_cpu_dout", {24'd0, bus.cpu_dout}, 32'd0);
    check("midrst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("midrst_cpu_wait", {31'd0, bus.cpu_wait}, 32'd1);
    a0 = ack_cnt;
    tick();
    tick();
    reset = 1'b0;
    m_served = 1'b0;
    tick();
    tick();
    check("aborted_no_ack", ack_cnt - a0, 32'd0);
    check("aborted_no_write", {24'd0, mem[13'h0300]}, 32'h00);
    w0 = we_cnt;
    pix(9'd49, 1'b0, 1'b0);
    pix(9'd50, 1'b0, 1'b0);
    pix(9'd51, 1'b0, 1'b0);
    check("post_rst_ack_count", ack_cnt - a0, 32'd1);
    check("post_rst_we_pulses", we_cnt - w0, 32'd1);
    check("post_rst_mem", {24'd0, mem[13'h0300]}, 32'h3C);
    cpu_drop();

    tick();
    tick();
    tick();
    check("bg_queue_empty", bg_q.size(), 32'd0);
    check("cpu_queue_empty", cpu_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
